ddc_nco_mixer: RTL and testbench

// Digital down-converter front end for the MSK demod: mixes real ADC samples with a

---
 rtl/ddc_nco_mixer.sv | 211 +++++++++++++++++++++
 tb/tb_ddc_nco_mixer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ddc_nco_mixer.sv
// ----------------------------------------------------------------------------
// ddc_nco_mixer
//
// Digital down-converter front end. Real input samples are multiplied by a
// numerically controlled complex oscillator e^-jwn to produce baseband I/Q.
// The output stream is valid-only with no backpressure, and one sample per
// clock is the maximum rate. Latency from d_in_val_i to d_out_val_o is
// exactly three clocks.
//
// Ports
//   clk          clock
//   rst          synchronous reset, active high
//   freq_word_i  NCO phase increment, unsigned (f = freq_word * fs / 2^PHASE_W)
//   freq_ld_i    load freq_word_i into the internal frequency register
//   phase_clr_i  force the NCO phase to zero
//   d_in_i       real input sample, signed
//   d_in_val_i   d_in_i valid; each high cycle carries one sample
//   i_out_o      baseband in-phase output, signed
//   q_out_o      baseband quadrature output, signed
//   d_out_val_o  i_out_o / q_out_o valid, one cycle per sample
// ----------------------------------------------------------------------------
module ddc_nco_mixer #(
    parameter int WI      = 16,
    parameter int WO      = 16,
    parameter int PHASE_W = 32,
    parameter int LUT_AW  = 10,
    parameter int WLUT    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PHASE_W-1:0]        freq_word_i,
    input  logic                      freq_ld_i,
    input  logic                      phase_clr_i,
    input  logic signed [WI-1:0]      d_in_i,
    input  logic                      d_in_val_i,
    output logic signed [WO-1:0]      i_out_o,
    output logic signed [WO-1:0]      q_out_o,
    output logic                      d_out_val_o
);

    localparam int  LUT_N  = 2 ** LUT_AW;
    localparam int  PW     = WI + WLUT;
    localparam real PI     = 3.14159265358979323846;
    localparam real LUT_FS = real'((2 ** (WLUT - 1)) - 1);

    // Rounding bias of one half LSB after the Q1.15 shift, held at the width
    // of the biased sum so the addition stays signed.
    localparam logic signed [PW+1:0] ROUND_BIAS =
        {{(WI + 3){1'b0}}, 1'b1, {(WLUT - 2){1'b0}}};
    localparam logic signed [PW+1:0] OUT_MAX = (PW + 2)'((2 ** (WO - 1)) - 1);
    localparam logic signed [PW+1:0] OUT_MIN = (PW + 2)'(-(2 ** (WO - 1)));

    // ------------------------------------------------------------------------
    // Full-cycle sine / cosine tables, evaluated at elaboration. Each entry is
    // round(full_scale * trig(2*pi*k/N)); floor(x+0.5) is used as the rounding
    // since no entry lands exactly on a half.
    // ------------------------------------------------------------------------
    logic signed [WLUT-1:0] cosTable [LUT_N];
    logic signed [WLUT-1:0] sinTable [LUT_N];

    for (genvar k = 0; k < LUT_N; k++) begin : g_lut
        localparam real ANG   = 2.0 * PI * real'(k) / real'(LUT_N);
        localparam int  COS_I = $rtoi($floor(LUT_FS * $cos(ANG) + 0.5));
        localparam int  SIN_I = $rtoi($floor(LUT_FS * $sin(ANG) + 0.5));
        assign cosTable[k] = WLUT'(COS_I);
        assign sinTable[k] = WLUT'(SIN_I);
    end

    // ------------------------------------------------------------------------
    // Round half up after the arithmetic shift, then clamp to the output
    // range. With a +/-full_scale table and WO == WI the clamp never engages,
    // but it keeps narrower output configurations safe.
    // ------------------------------------------------------------------------
    function automatic logic signed [WO-1:0] roundSat(input logic signed [PW:0] v);
        logic signed [PW+1:0] biased;
        logic signed [PW+1:0] shifted;
        biased  = $signed({v[PW], v}) + ROUND_BIAS;
        shifted = biased >>> (WLUT - 1);
        if (shifted > OUT_MAX) begin
            return OUT_MAX[WO-1:0];
        end else if (shifted < OUT_MIN) begin
            return OUT_MIN[WO-1:0];
        end else begin
            return WO'(shifted);
        end
    endfunction

    // ------------------------------------------------------------------------
    // NCO phase control. A sample taken with phase_clr_i uses phase zero and
    // leaves the accumulator one step on; a clear without a sample just parks
    // the phase at zero. Idle cycles never advance the phase.
    // ------------------------------------------------------------------------
    logic [PHASE_W-1:0] freq_q;
    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] phase_d;
    logic [LUT_AW-1:0]  lutAddr;

    always_comb begin
        phase_d = phase_q;
        lutAddr = phase_q[PHASE_W-1 -: LUT_AW];
        if (phase_clr_i) begin
            lutAddr = '0;
            phase_d = d_in_val_i ? freq_q : '0;
        end else if (d_in_val_i) begin
            phase_d = phase_q + freq_q;
        end
    end

    // The advance above always uses freq_q as it stood before this edge, so a
    // load coinciding with a sample only affects the following sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            freq_q  <= '0;
            phase_q <= '0;
        end else begin
            if (freq_ld_i) begin
                freq_q <= freq_word_i;
            end
            phase_q <= phase_d;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 1: capture the sample together with its table entries.
    // ------------------------------------------------------------------------
    logic                   s1Val_q;
    logic signed [WI-1:0]   s1Data_q;
    logic signed [WLUT-1:0] s1Cos_q;
    logic signed [WLUT-1:0] s1Sin_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1Val_q  <= 1'b0;
            s1Data_q <= '0;
            s1Cos_q  <= '0;
            s1Sin_q  <= '0;
        end else begin
            s1Val_q <= d_in_val_i;
            if (d_in_val_i) begin
                s1Data_q <= d_in_i;
                s1Cos_q  <= cosTable[lutAddr];
                s1Sin_q  <= sinTable[lutAddr];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: full-precision products. Operands are sign extended to the
    // product width so the multiply is exact. The quadrature product is
    // negated one bit wider so that negating the most negative product
    // cannot wrap.
    // ------------------------------------------------------------------------
    logic signed [PW-1:0] prodI;
    logic signed [PW-1:0] prodQ;
    logic signed [PW:0]   s2I_d;
    logic signed [PW:0]   s2Q_d;

    always_comb begin
        prodI = $signed({{WLUT{s1Data_q[WI-1]}}, s1Data_q}) *
                $signed({{WI{s1Cos_q[WLUT-1]}}, s1Cos_q});
        prodQ = $signed({{WLUT{s1Data_q[WI-1]}}, s1Data_q}) *
                $signed({{WI{s1Sin_q[WLUT-1]}}, s1Sin_q});
        s2I_d = $signed({prodI[PW-1], prodI});
        s2Q_d = -$signed({prodQ[PW-1], prodQ});
    end

    logic               s2Val_q;
    logic signed [PW:0] s2I_q;
    logic signed [PW:0] s2Q_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2Val_q <= 1'b0;
            s2I_q   <= '0;
            s2Q_q   <= '0;
        end else begin
            s2Val_q <= s1Val_q;
            if (s1Val_q) begin
                s2I_q <= s2I_d;
                s2Q_q <= s2Q_d;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 3: round, saturate and register the outputs. The data registers
    // load only with a valid sample, so the outputs hold between samples.
    // ------------------------------------------------------------------------
    logic                 outVal_q;
    logic signed [WO-1:0] outI_q;
    logic signed [WO-1:0] outQ_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            outVal_q <= 1'b0;
            outI_q   <= '0;
            outQ_q   <= '0;
        end else begin
            outVal_q <= s2Val_q;
            if (s2Val_q) begin
                outI_q <= roundSat(s2I_q);
                outQ_q <= roundSat(s2Q_q);
            end
        end
    end

    assign i_out_o     = outI_q;
    assign q_out_o     = outQ_q;
    assign d_out_val_o = outVal_q;

endmodule

// File: tb/tb_ddc_nco_mixer.sv
// ----------------------------------------------------------------------------
// tb_ddc_nco_mixer
//
// Directed bench for ddc_nco_mixer. The driver pushes the expected I/Q and
// the issue cycle of each sample into a queue; a separate monitor pops one
// entry whenever d_out_val_o is high. The monitor also checks the latency,
// the reset state, and that the outputs hold between samples.
//
// The expected values come from the quarter-turn table entries (+/-32767 or
// 0). With d = 16384, a positive product rounds up to 16384. A negative
// product sits exactly at -16383.5, and round-half-up takes it to -16383.
// ----------------------------------------------------------------------------
module tb_ddc_nco_mixer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic [31:0]        freqWord;
    logic               freqLd;
    logic               phaseClr;
    logic signed [15:0] dIn;
    logic               dInVal;
    logic signed [15:0] iOut;
    logic signed [15:0] qOut;
    logic               dOutVal;

    ddc_nco_mixer dut (
        .clk         (clk),
        .rst         (rst),
        .freq_word_i (freqWord),
        .freq_ld_i   (freqLd),
        .phase_clr_i (phaseClr),
        .d_in_i      (dIn),
        .d_in_val_i  (dInVal),
        .i_out_o     (iOut),
        .q_out_o     (qOut),
        .d_out_val_o (dOutVal)
    );

    // Free-running cycle counter used to time-stamp issued samples.
    int cycleCnt = 0;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    typedef struct {
        logic signed [15:0] i;
        logic signed [15:0] q;
        int                 issue;
    } expT;

    expT   expQ[$];
    string tagQ[$];
    int    checks   = 0;
    int    failures = 0;

    task automatic checkOutput(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("[TB] FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Drive one valid sample for one cycle and queue its expected result.
    task automatic applyStimulus(input logic signed [15:0] d,
                                 input logic signed [15:0] expI,
                                 input logic signed [15:0] expQv,
                                 input logic ld, input logic [31:0] fw,
                                 input logic clr, input string tag);
        expT e;
        e.i     = expI;
        e.q     = expQv;
        e.issue = cycleCnt;
        expQ.push_back(e);
        tagQ.push_back(tag);
        dIn      = d;
        dInVal   = 1'b1;
        freqLd   = ld;
        freqWord = fw;
        phaseClr = clr;
        @(posedge clk);
        #1;
        dInVal   = 1'b0;
        freqLd   = 1'b0;
        phaseClr = 1'b0;
    endtask

    // Frequency load and/or phase clear on a cycle without a sample.
    task automatic ctrlOnly(input logic ld, input logic [31:0] fw, input logic clr);
        freqLd   = ld;
        freqWord = fw;
        phaseClr = clr;
        @(posedge clk);
        #1;
        freqLd   = 1'b0;
        phaseClr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: on each falling edge, check the reset state, a queued output,
    // or that the outputs held their last values.
    logic               rstAtEdge;
    logic signed [15:0] lastI = '0;
    logic signed [15:0] lastQ = '0;

    initial begin
        expT   e;
        string t;
        forever begin
            @(posedge clk);
            rstAtEdge = rst;
            @(negedge clk);
            if (rstAtEdge) begin
                checkOutput("reset_val", int'(dOutVal), 0);
                checkOutput("reset_i", int'(iOut), 0);
                checkOutput("reset_q", int'(qOut), 0);
                lastI = '0;
                lastQ = '0;
            end else if (dOutVal) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_output", int'(dOutVal), 0);
                end else begin
                    e = expQ.pop_front();
                    t = tagQ.pop_front();
                    checkOutput({t, "_i"}, int'(iOut), int'(e.i));
                    checkOutput({t, "_q"}, int'(qOut), int'(e.q));
                    checkOutput({t, "_latency"}, cycleCnt - e.issue, 3);
                    lastI = e.i;
                    lastQ = e.q;
                end
            end else begin
                checkOutput("hold_i", int'(iOut), int'(lastI));
                checkOutput("hold_q", int'(qOut), int'(lastQ));
            end
        end
    end

    // Quarter-turn sequence for d = 16384 at fs/4 (phases 0, 90, 180, 270).
    int t2I[4] = '{16384, 0, -16383, 0};
    int t2Q[4] = '{0, -16383, 0, 16384};
    // The phase clear lands on sample 6 (index 5), which restarts the
    // sequence at phase 0.
    int t3I[8] = '{16384, 0, -16383, 0, 16384, 16384, 0, -16383};
    int t3Q[8] = '{0, -16383, 0, 16384, 0, 0, -16383, 0};
    // Sample 3 (index 2) loads fs/2 but still steps by fs/4, so sample 4 sits
    // at 270 degrees. After that, the phase alternates between 90 and 270.
    int t4I[6] = '{16384, 0, -16383, 0, 0, 0};
    int t4Q[6] = '{0, -16383, 0, 16384, -16383, 16384};

    initial begin
        rst      = 1'b1;
        freqWord = '0;
        freqLd   = 1'b0;
        phaseClr = 1'b0;
        dIn      = '0;
        dInVal   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        $display("[TB] test 1: zero frequency, constant input");
        applyStimulus(16'sd1000, 16'sd1000, 16'sd0, 1'b1, 32'd0, 1'b0, "t1_s0");
        for (int n = 1; n < 4; n++)
            applyStimulus(16'sd1000, 16'sd1000, 16'sd0, 1'b0, 32'd0, 1'b0,
                          $sformatf("t1_s%0d", n));
        idle(4);

        $display("[TB] test 2: fs/4 back-to-back");
        ctrlOnly(1'b1, 32'h4000_0000, 1'b1);
        for (int n = 0; n < 8; n++)
            applyStimulus(16'sd16384, 16'(t2I[n % 4]), 16'(t2Q[n % 4]),
                          1'b0, 32'd0, 1'b0, $sformatf("t2_s%0d", n));
        idle(4);

        $display("[TB] test 3: phase clear with sample 6");
        ctrlOnly(1'b0, 32'd0, 1'b1);
        for (int n = 0; n < 8; n++)
            applyStimulus(16'sd16384, 16'(t3I[n]), 16'(t3Q[n]), 1'b0, 32'd0,
                          (n == 5), $sformatf("t3_s%0d", n));
        idle(4);

        $display("[TB] test 4: fs/2 load with sample 3");
        ctrlOnly(1'b0, 32'd0, 1'b1);
        for (int n = 0; n < 6; n++)
            applyStimulus(16'sd16384, 16'(t4I[n]), 16'(t4Q[n]), (n == 2),
                          32'h8000_0000, 1'b0, $sformatf("t4_s%0d", n));
        idle(4);

        $display("[TB] test 5: fs/4 with a sample every third clock");
        ctrlOnly(1'b1, 32'h4000_0000, 1'b1);
        for (int n = 0; n < 8; n++) begin
            applyStimulus(16'sd16384, 16'(t2I[n % 4]), 16'(t2Q[n % 4]),
                          1'b0, 32'd0, 1'b0, $sformatf("t5_s%0d", n));
            idle(2);
        end
        idle(5);

        $display("[TB] test 6: reset with two samples in flight");
        applyStimulus(16'sd5000, 16'sd0, 16'sd0, 1'b0, 32'd0, 1'b0, "t6_flushed0");
        applyStimulus(16'sd5000, 16'sd0, 16'sd0, 1'b0, 32'd0, 1'b0, "t6_flushed1");
        rst = 1'b1;
        expQ.delete();
        tagQ.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4);
        applyStimulus(16'sd1000, 16'sd1000, 16'sd0, 1'b0, 32'd0, 1'b0, "t6_post0");
        applyStimulus(16'sd1000, 16'sd1000, 16'sd0, 1'b0, 32'd0, 1'b0, "t6_post1");

        for (int n = 0; n < 20 && expQ.size() != 0; n++) @(posedge clk);
        idle(2);
        checkOutput("drain_empty", expQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
